store_narrow: RTL and testbench

Store-path lane packer: the write-side counterpart of the load-side halfword/byte extender. Accepts a 32-bit store word with size and byte address from the datapath and drives a 16-bit little-endian data-memory write port, producing byte enables and splitting word stores into two halfword beats. Sits between the execute-stage store request and the data memory.

---
 rtl/store_narrow_if.sv | 34 +++
 rtl/store_narrow.sv | 150 +++++++++++++++
 tb/tb_store_narrow.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_narrow_if.sv
// store_narrow_if: request-side and memory-write-side bundle for store_narrow.
// The slave modport is the packer's view; master is the requester/memory view.
`default_nettype none

interface store_narrow_if #(
   parameter int ADDR_W = 32
);
   logic              reqValid_in;
   logic              reqReady_out;
   logic [ADDR_W-1:0] addr_in;
   logic [31:0]       word_in;
   logic [1:0]        size_in;
   logic              memValid_out;
   logic              memReady_in;
   logic [ADDR_W-1:0] memAddr_out;
   logic [15:0]       memData_out;
   logic [1:0]        memByteEn_out;
   logic              done_out;
   logic              misalign_out;

   modport slave (
      input  reqValid_in, addr_in, word_in, size_in, memReady_in,
      output reqReady_out, memValid_out, memAddr_out, memData_out,
             memByteEn_out, done_out, misalign_out
   );

   modport master (
      output reqValid_in, addr_in, word_in, size_in, memReady_in,
      input  reqReady_out, memValid_out, memAddr_out, memData_out,
             memByteEn_out, done_out, misalign_out
   );
endinterface

`default_nettype wire

// File: rtl/store_narrow.sv
// store_narrow: packs byte/half/word stores onto a 16-bit little-endian write port.
// Define MISALIGN_TRAP_EN to drop misaligned half/word stores with a misalign pulse.
`default_nettype none

module store_narrow #(
   parameter int ADDR_W = 32
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   store_narrow_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BEAT_LO = 2'd1,
      BEAT_HI = 2'd2
   } state_t;

   state_t            state;
   logic              req_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_data;
   logic [1:0]        mem_be;
   logic              done;
   logic              two_beats;
   logic [15:0]       hi_data;

   logic              trap;
   logic [ADDR_W-1:0] half_addr;
   logic [ADDR_W-1:0] word_addr;

   assign half_addr = {bus.addr_in[ADDR_W-1:1], 1'b0};
   // Word stores always start on a 4-byte boundary; misaligned low bits are dropped.
   assign word_addr = {bus.addr_in[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   assign trap = (bus.size_in == 2'b01 && bus.addr_in[0]) ||
                 (bus.size_in == 2'b10 && bus.addr_in[1:0] != 2'b00);
   assign bus.misalign_out = misalign;
`else
   assign trap             = 1'b0;
   assign bus.misalign_out = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         mem_be    <= '0;
         done      <= 1'b0;
         two_beats <= 1'b0;
         hi_data   <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.reqValid_in) begin
                  if (trap) begin
                     done <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                     misalign <= 1'b1;
`endif
                  end else begin
                     case (bus.size_in)
                        2'b00: begin
                           mem_addr  <= half_addr;
                           mem_data  <= {bus.word_in[7:0], bus.word_in[7:0]};
                           mem_be    <= bus.addr_in[0] ? 2'b10 : 2'b01;
                           two_beats <= 1'b0;
                           mem_valid <= 1'b1;
                           req_ready <= 1'b0;
                           state     <= BEAT_LO;
                        end
                        2'b01: begin
                           mem_addr  <= half_addr;
                           mem_data  <= bus.word_in[15:0];
                           mem_be    <= 2'b11;
                           two_beats <= 1'b0;
                           mem_valid <= 1'b1;
                           req_ready <= 1'b0;
                           state     <= BEAT_LO;
                        end
                        2'b10: begin
                           mem_addr  <= word_addr;
                           mem_data  <= bus.word_in[15:0];
                           mem_be    <= 2'b11;
                           two_beats <= 1'b1;
                           hi_data   <= bus.word_in[31:16];
                           mem_valid <= 1'b1;
                           req_ready <= 1'b0;
                           state     <= BEAT_LO;
                        end
                        default: begin
                           // Reserved size: retire immediately with no beats.
                           done <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            BEAT_LO: begin
               if (bus.memReady_in) begin
                  if (two_beats) begin
                     mem_addr <= mem_addr + ADDR_W'(2);
                     mem_data <= hi_data;
                     state    <= BEAT_HI;
                  end else begin
                     mem_valid <= 1'b0;
                     req_ready <= 1'b1;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            BEAT_HI: begin
               if (bus.memReady_in) begin
                  mem_valid <= 1'b0;
                  req_ready <= 1'b1;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               mem_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.reqReady_out  = req_ready;
   assign bus.memValid_out  = mem_valid;
   assign bus.memAddr_out   = mem_addr;
   assign bus.memData_out   = mem_data;
   assign bus.memByteEn_out = mem_be;
   assign bus.done_out      = done;
endmodule

`default_nettype wire

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed stimulus against a beat-queue model of the store packer.
`default_nettype none

module tb_store_narrow;
   logic clk_in;
   logic rst_n_in;
   int   n_checks;
   int   n_fail;
   bit   started;

   store_narrow_if #(.ADDR_W(32)) bus ();

   store_narrow #(.ADDR_W(32)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus.slave)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] a;
      logic [15:0] d;
      logic [1:0]  e;
   } beat_t;

   beat_t q[$];
   bit    m_done;
   bit    m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request expands into a list of beats; each handshake pops one.
   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         q.delete();
         m_done = 1'b0;
         m_mis  = 1'b0;
      end else begin
         m_done = 1'b0;
         m_mis  = 1'b0;
         if (q.size() != 0) begin
            if (bus.memReady_in) begin
               void'(q.pop_front());
               if (q.size() == 0) m_done = 1'b1;
            end
         end else if (bus.reqValid_in) begin
            logic [31:0] a;
            logic [31:0] w;
            bit          bad;
            a   = bus.addr_in;
            w   = bus.word_in;
            bad = 1'b0;
`ifdef MISALIGN_TRAP_EN
            bad = (bus.size_in == 2'd1 && a % 2 != 0) || (bus.size_in == 2'd2 && a % 4 != 0);
`endif
            if (bad) begin
               m_done = 1'b1;
               m_mis  = 1'b1;
            end else if (bus.size_in == 2'd0) begin
               q.push_back('{a - (a % 2), {w[7:0], w[7:0]}, (a % 2 != 0) ? 2'b10 : 2'b01});
            end else if (bus.size_in == 2'd1) begin
               q.push_back('{a - (a % 2), w[15:0], 2'b11});
            end else if (bus.size_in == 2'd2) begin
               q.push_back('{a - (a % 4), w[15:0], 2'b11});
               q.push_back('{a - (a % 4) + 32'd2, w[31:16], 2'b11});
            end else begin
               m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk_in) begin
      if (rst_n_in && started) begin
         chk("memValid", {31'd0, bus.memValid_out}, {31'd0, q.size() != 0});
         chk("reqReady", {31'd0, bus.reqReady_out}, {31'd0, q.size() == 0});
         chk("done", {31'd0, bus.done_out}, {31'd0, m_done});
         chk("misalign", {31'd0, bus.misalign_out}, {31'd0, m_mis});
         if (q.size() != 0) begin
            chk("memAddr", bus.memAddr_out, q[0].a);
            chk("memData", {16'd0, bus.memData_out}, {16'd0, q[0].d});
            chk("memByteEn", {30'd0, bus.memByteEn_out}, {30'd0, q[0].e});
         end
      end
   end

   // Present a request after a rising edge and drop it once it has been accepted.
   task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [1:0] s);
      int n;
      @(posedge clk_in);
      #1;
      bus.reqValid_in = 1'b1;
      bus.addr_in     = a;
      bus.word_in     = w;
      bus.size_in     = s;
      n = 0;
      @(negedge clk_in);
      while (!bus.reqReady_out && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk_in);
      #1;
      bus.reqValid_in = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      started  = 1'b0;
      rst_n_in = 1'b0;
      bus.reqValid_in = 1'b0;
      bus.addr_in     = '0;
      bus.word_in     = '0;
      bus.size_in     = '0;
      bus.memReady_in = 1'b1;
      repeat (2) @(negedge clk_in);
      chk("rst_reqReady", {31'd0, bus.reqReady_out}, 32'd1);
      chk("rst_memValid", {31'd0, bus.memValid_out}, 32'd0);
      chk("rst_memAddr", bus.memAddr_out, 32'd0);
      chk("rst_memData", {16'd0, bus.memData_out}, 32'd0);
      chk("rst_memByteEn", {30'd0, bus.memByteEn_out}, 32'd0);
      chk("rst_done", {31'd0, bus.done_out}, 32'd0);
      chk("rst_misalign", {31'd0, bus.misalign_out}, 32'd0);
      #2 rst_n_in = 1'b1;
      started = 1'b1;

      // Byte store to the high lane
      send(32'h1003, 32'hAABBCCDD, 2'b00);
      @(negedge clk_in);
      chk("byte_addr", bus.memAddr_out, 32'h1002);
      chk("byte_data", {16'd0, bus.memData_out}, 32'hDDDD);
      chk("byte_be", {30'd0, bus.memByteEn_out}, 32'd2);
      @(negedge clk_in);
      chk("byte_done", {31'd0, bus.done_out}, 32'd1);

      // Aligned word store: two beats
      send(32'h2000, 32'h12345678, 2'b10);
      @(negedge clk_in);
      chk("word_lo_data", {16'd0, bus.memData_out}, 32'h5678);
      @(negedge clk_in);
      chk("word_hi_addr", bus.memAddr_out, 32'h2002);
      chk("word_hi_data", {16'd0, bus.memData_out}, 32'h1234);
      @(negedge clk_in);
      chk("word_done", {31'd0, bus.done_out}, 32'd1);

      // Half store with memory stalled for four cycles
      bus.memReady_in = 1'b0;
      send(32'h0010, 32'h0000BEEF, 2'b01);
      repeat (4) begin
         @(negedge clk_in);
         chk("stall_data", {16'd0, bus.memData_out}, 32'hBEEF);
      end
      @(posedge clk_in);
      #1 bus.memReady_in = 1'b1;
      repeat (3) @(negedge clk_in);

      // Reserved size retires without beats
      send(32'h0040, 32'h0, 2'b11);
      @(negedge clk_in);
      chk("rsv_done", {31'd0, bus.done_out}, 32'd1);
      chk("rsv_valid", {31'd0, bus.memValid_out}, 32'd0);

      // Misaligned word store
      send(32'h3001, 32'hCAFEF00D, 2'b10);
      @(negedge clk_in);
`ifdef MISALIGN_TRAP_EN
      chk("mis_pulse", {31'd0, bus.misalign_out}, 32'd1);
      chk("mis_done", {31'd0, bus.done_out}, 32'd1);
`else
      chk("mis_lo_addr", bus.memAddr_out, 32'h3000);
      chk("mis_lo_data", {16'd0, bus.memData_out}, 32'hF00D);
`endif
      repeat (3) @(negedge clk_in);

      // Asynchronous reset during the high beat
      send(32'h4000, 32'h87654321, 2'b10);
      @(posedge clk_in);
      #1 rst_n_in = 1'b0;
      #1;
      chk("arst_valid", {31'd0, bus.memValid_out}, 32'd0);
      chk("arst_ready", {31'd0, bus.reqReady_out}, 32'd1);
      @(negedge clk_in);
      #2 rst_n_in = 1'b1;
      @(negedge clk_in);
      chk("arst_no_done", {31'd0, bus.done_out}, 32'd0);
      send(32'h5000, 32'h00000011, 2'b00);
      repeat (3) @(negedge clk_in);

      // Back-to-back halves with request valid held
      @(posedge clk_in);
      #1;
      bus.reqValid_in = 1'b1;
      bus.addr_in     = 32'h0100;
      bus.word_in     = 32'h1111;
      bus.size_in     = 2'b01;
      @(posedge clk_in);
      #1;
      bus.addr_in = 32'h0200;
      bus.word_in = 32'h2222;
      @(negedge clk_in);
      chk("b2b_first", {16'd0, bus.memData_out}, 32'h1111);
      @(negedge clk_in);
      chk("b2b_done", {31'd0, bus.done_out}, 32'd1);
      chk("b2b_ready", {31'd0, bus.reqReady_out}, 32'd1);
      @(posedge clk_in);
      #1 bus.reqValid_in = 1'b0;
      @(negedge clk_in);
      chk("b2b_second", {16'd0, bus.memData_out}, 32'h2222);
      chk("b2b_addr", bus.memAddr_out, 32'h0200);
      repeat (4) @(negedge clk_in);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
